// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl -- bit-serial unsigned adder controller
//
// One 1-bit full-adder cell (two half_adder instances plus an OR gate) is
// time-shared across a WIDTH-bit addition. The operands are shifted through
// the cell LSB-first, one bit per clock. The result is returned on a second
// handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. in_ready is high only in IDLE.
// out_valid is high only in DONE. Because of this the two transfers can never
// coincide. s/c (and ovf) are held stable for as long as out_valid is high.
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the ovf output. ovf is the
// signed two's-complement overflow flag captured in the final bit-cycle.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand pair a/b valid
//   in_ready   out  1      ready to accept operands (IDLE only)
//   a, b       in   WIDTH  unsigned operands
//   out_valid  out  1      s/c hold a completed result (DONE)
//   out_ready  in   1      consumer accepts the result
//   s          out  WIDTH  (a+b) mod 2^WIDTH
//   c          out  1      carry-out, bit WIDTH of a+b
//   ovf        out  1      signed overflow (SERIAL_ADD_OVF_EN only)
//   busy       out  1      high in SHIFT and DONE
// -----------------------------------------------------------------------------

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // state_q is the single FSM state register; checkers can bind to it.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Shared full-adder cell.
  logic ha0_s, ha0_c, ha1_c;
  logic cell_sum, cell_cout;

  half_adder u_ha0 (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder u_ha1 (
    .x_i (ha0_s),
    .y_i (carry_q),
    .s_o (cell_sum),
    .c_o (ha1_c)
  );

  assign cell_cout = ha0_c | ha1_c;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of the
        // result has arrived at the LSB.
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {cell_sum, s_sh_q[WIDTH-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          // The last sum bit is folded in directly; s_sh_q does not yet
          // contain it on this edge.
          s_d     = {cell_sum, s_sh_q[WIDTH-1:1]};
          c_d     = cell_cout;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB during the final bit-cycle.
          ovf_d   = carry_q ^ cell_cout;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign s         = s_q;
  assign c         = c_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl -- self-checking bench for serial_add_ctrl.
// A WIDTH=8 instance runs table vectors, hand-written corner sequences and
// random additions against a reference model. A WIDTH=2 instance is checked
// exhaustively. Build with +define+SERIAL_ADD_OVF_EN to cover ovf as well.
// -----------------------------------------------------------------------------

module tb_serial_add_ctrl;

  localparam int W  = 8;
  localparam int W2 = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT W=8
  logic         in_valid, in_ready, out_valid, out_ready, c, busy;
  logic [W-1:0] a, b, s;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c         (c),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  // ---------------------------------------------------------------- DUT W=2
  logic          in_valid2, in_ready2, out_valid2, out_ready2, c2, busy2;
  logic [W2-1:0] a2, b2, s2;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf2;
`endif

  serial_add_ctrl #(.WIDTH(W2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .s         (s2),
    .c         (c2),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf2),
`endif
    .busy      (busy2)
  );

  // ---------------------------------------------------------------- scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  logic         exp_ovf_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = int'(x) + int'(y);
    return r[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = int'(x);
    sy = int'(y);
    if (sx >= 2**(W-1)) sx = sx - 2**W;
    if (sy >= 2**(W-1)) sy = sy - 2**W;
    r = sx + sy;
    return (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
  endfunction

  // ---------------------------------------------------------------- driver
  // Called at a negedge with the DUT in IDLE. Drives one addition, scribbles
  // over a/b/in_valid/out_ready while shifting, holds DONE for 'hold' cycles
  // and then releases it.
  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input int hold,
                         output logic [W-1:0] got_s, output logic got_c, output logic got_ovf);
    int         lat;
    bit         seen;
    logic [W:0] e;
    logic       eo;
    check("in_ready_idle", in_ready, 1);
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    exp_q.push_back(ref_sum(xa, xb));
    exp_ovf_q.push_back(ref_ovf(xa, xb));
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        check("shift_busy", busy, 1);
        check("shift_in_ready", in_ready, 0);
        in_valid  = 1'($urandom_range(0, 1));
        a         = W'($urandom_range(0, 2**W - 1));
        b         = W'($urandom_range(0, 2**W - 1));
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    e  = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    got_s   = s;
    got_c   = c;
    got_ovf = 1'b0;
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, W + 1);
    check("sum", s, e[W-1:0]);
    check("carry", c, e[W]);
`ifdef SERIAL_ADD_OVF_EN
    got_ovf = ovf;
    check("ovf", ovf, eo);
`else
    if (eo === 1'bx) check("ovf_model", eo, 0);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_s", s, e[W-1:0]);
      check("hold_c", c, e[W]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vs;
    logic         vc;
    logic         vovf;
    int           hold;
  } vec_t;

  vec_t tab[8];

  initial begin
    logic [W-1:0] gs;
    logic         gc, go;
    bit           seen2;

    tab[0] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 0};
    tab[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1};
    tab[2] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 5};
    tab[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 2};
    tab[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 0};
    tab[5] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1};
    tab[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    tab[7] = '{8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 3};

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    a2         = '0;
    b2         = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_s", s, 0);
    check("rst_c", c, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      run_add(tab[i].va, tab[i].vb, tab[i].hold, gs, gc, go);
      check("tab_s", gs, tab[i].vs);
      check("tab_c", gc, tab[i].vc);
`ifdef SERIAL_ADD_OVF_EN
      check("tab_ovf", go, tab[i].vovf);
`endif
    end

    // Reset at bit-cycle 4 of 0x80+0x80 abandons the operation.
    a        = 8'h80;
    b        = 8'h80;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h01;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_s", s, 0);
    check("midrst_c", c, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf_q.delete();
    @(negedge clk);
    check("postrst_out_valid", out_valid, 0);
    run_add(8'h03, 8'h04, 0, gs, gc, go);
    check("postrst_s", gs, 8'h07);
    check("postrst_c", gc, 0);

    // Random additions against the model, with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      run_add(W'($urandom_range(0, 2**W - 1)), W'($urandom_range(0, 2**W - 1)),
              $urandom_range(0, 3), gs, gc, go);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // WIDTH=2 exhaustive.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        check("w2_in_ready", in_ready2, 1);
        a2        = 2'(i);
        b2        = 2'(j);
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        a2        = 2'(j);
        b2        = 2'(i + 1);
        seen2     = 1'b0;
        for (int k = 0; k < 10 && !seen2; k++) begin
          if (out_valid2) seen2 = 1'b1;
          else @(negedge clk);
        end
        if (!seen2) begin
          check("w2_timeout", 0, 1);
        end else begin
          check("w2_sum", {c2, s2}, i + j);
        end
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
